// File: rtl/float_round_arbiter_pkg.sv
// Shared FPU definitions: rounding-mode enum, RISC-V rm encodings and
// helpers for legality checks and encoding-to-enum conversion.
package float_round_arbiter_pkg;

  typedef enum logic [2:0] {
    RNE = 3'b000,
    RTZ = 3'b001,
    RDN = 3'b010,
    RUP = 3'b011,
    RMM = 3'b100
  } round_mode_t;

  localparam logic [2:0] RM_RNE = 3'b000;
  localparam logic [2:0] RM_RTZ = 3'b001;
  localparam logic [2:0] RM_RDN = 3'b010;
  localparam logic [2:0] RM_RUP = 3'b011;
  localparam logic [2:0] RM_RMM = 3'b100;
  localparam logic [2:0] RM_DYN = 3'b111;

  function automatic logic is_legal_rm(input logic [2:0] rm);
    return (rm <= RM_RMM);
  endfunction

  // Illegal encodings map to RNE; callers must mask the result separately.
  function automatic round_mode_t to_round_mode(input logic [2:0] rm);
    round_mode_t m;
    case (rm)
      RM_RNE:  m = RNE;
      RM_RTZ:  m = RTZ;
      RM_RDN:  m = RDN;
      RM_RUP:  m = RUP;
      RM_RMM:  m = RMM;
      default: m = RNE;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/float_rounder.sv
// Combinational mantissa rounder: adds one ulp to A according to the
// rounding mode, sign and guard/sticky bits; Y carries the carry-out.
module float_rounder
  import float_round_arbiter_pkg::*;
#(
  parameter int N = 4
) (
  input  logic        sign,
  input  logic [N-1:0] a,
  input  logic [1:0]  sticky,
  input  round_mode_t mode,
  output logic [N:0]  y
);

  // sticky[1] is the guard (half-ulp) bit, sticky[0] ORs everything below it.
  function automatic logic round_inc(input round_mode_t m, input logic s,
                                     input logic lsb, input logic g,
                                     input logic st);
    logic inc;
    case (m)
      RNE:     inc = g & (st | lsb);
      RTZ:     inc = 1'b0;
      RDN:     inc = s & (g | st);
      RUP:     inc = ~s & (g | st);
      RMM:     inc = g;
      default: inc = 1'b0;
    endcase
    return inc;
  endfunction

  logic inc;

  always_comb begin
    inc = round_inc(mode, sign, a[0], sticky[1], sticky[0]);
    y   = {1'b0, a} + {{N{1'b0}}, inc};
  end

endmodule

// File: rtl/float_round_arbiter.sv
// Round-robin arbiter sharing one float_rounder between two requesters,
// with dynamic rounding-mode resolution and a registered tagged response.
module float_round_arbiter
  import float_round_arbiter_pkg::*;
#(
  parameter int N = 4
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic [1:0]          req_valid,
  output logic [1:0]          req_ready,
  input  logic [1:0]          req_sign,
  input  logic [1:0][N-1:0]   req_a,
  input  logic [1:0][1:0]     req_sticky,
  input  logic [1:0][2:0]     req_rm,
  input  logic [2:0]          frm,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic                rsp_id,
  output logic [N:0]          rsp_y,
  output logic                rsp_inexact,
  output logic                rsp_illegal
);

  logic        ptr_q, ptr_d;
  logic        vld_p1_q, vld_p1_d;
  logic        id_p1_q, id_p1_d;
  logic [N:0]  y_p1_q, y_p1_d;
  logic        inexact_p1_q, inexact_p1_d;
  logic        illegal_p1_q, illegal_p1_d;

  logic        free;
  logic [1:0]  grant;
  logic        xfer;
  logic        sel;
  logic [2:0]  rm_sel;
  logic [2:0]  rm_eff;
  logic        illegal;
  round_mode_t mode;
  logic        sel_sign;
  logic [N-1:0] sel_a;
  logic [1:0]  sel_sticky;
  logic [N:0]  rnd_y;

  // Stage 0: arbitration, mode resolution and operand select
  always_comb begin
    free     = ~vld_p1_q | rsp_ready;
    grant[0] = req_valid[0] & (~ptr_q | ~req_valid[1]);
    grant[1] = req_valid[1] & ( ptr_q | ~req_valid[0]);
    // Handshakes are suppressed while reset is held so no transfer is seen.
    req_ready = (reset_n && free) ? grant : 2'b00;
    xfer      = |req_ready;
    sel       = grant[1];

    rm_sel     = req_rm[sel];
    rm_eff     = (rm_sel == RM_DYN) ? frm : rm_sel;
    illegal    = ~is_legal_rm(rm_eff);
    mode       = to_round_mode(rm_eff);
    sel_sign   = req_sign[sel];
    sel_a      = req_a[sel];
    sel_sticky = req_sticky[sel];
  end

  float_rounder #(.N(N)) u_rounder (
    .sign   (sel_sign),
    .a      (sel_a),
    .sticky (sel_sticky),
    .mode   (mode),
    .y      (rnd_y)
  );

  always_comb begin
    ptr_d        = ptr_q;
    vld_p1_d     = vld_p1_q;
    id_p1_d      = id_p1_q;
    y_p1_d       = y_p1_q;
    inexact_p1_d = inexact_p1_q;
    illegal_p1_d = illegal_p1_q;
    if (xfer) begin
      ptr_d        = ~sel;
      vld_p1_d     = 1'b1;
      id_p1_d      = sel;
      y_p1_d       = illegal ? '0 : rnd_y;
      inexact_p1_d = (|sel_sticky) & ~illegal;
      illegal_p1_d = illegal;
    end else if (rsp_ready) begin
      vld_p1_d = 1'b0;
    end
  end

  // Stage 1: response register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q        <= 1'b0;
      vld_p1_q     <= 1'b0;
      id_p1_q      <= 1'b0;
      y_p1_q       <= '0;
      inexact_p1_q <= 1'b0;
      illegal_p1_q <= 1'b0;
    end else begin
      ptr_q        <= ptr_d;
      vld_p1_q     <= vld_p1_d;
      id_p1_q      <= id_p1_d;
      y_p1_q       <= y_p1_d;
      inexact_p1_q <= inexact_p1_d;
      illegal_p1_q <= illegal_p1_d;
    end
  end

  assign rsp_valid   = vld_p1_q;
  assign rsp_id      = id_p1_q;
  assign rsp_y       = y_p1_q;
  assign rsp_inexact = inexact_p1_q;
  assign rsp_illegal = illegal_p1_q;

endmodule
